// File: rtl/match_event_counter.sv
// Rising-edge event counter behind a 1001 sequence detector, with sticky threshold alarm,
// sticky overflow flag and a one-shot snapshot port. Define MATCH_CNT_SAT_EN to saturate instead of wrap.
module match_event_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             z_in,
   input  logic             en,
   input  logic             clr,
   input  logic [CNT_W-1:0] thresh,
   input  logic             rd_req,
   output logic [CNT_W-1:0] count,
   output logic             match_pulse,
   output logic             alarm,
   output logic             ovf,
   output logic             rd_valid,
   output logic [CNT_W-1:0] rd_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      ALARM = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic             z_q, z_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             match_pulse_q, match_pulse_d;
   logic             alarm_q, alarm_d;
   logic             ovf_q, ovf_d;
   logic             rd_valid_q, rd_valid_d;
   logic [CNT_W-1:0] rd_data_q, rd_data_d;

   logic             event_hit;
   logic             at_max;
   logic             counting;
   logic [CNT_W-1:0] count_inc;
   logic             thresh_reached;

   assign event_hit = z_in & ~z_q;
   assign at_max    = (count_q == CNT_MAX);
   assign counting  = en && ((state_q == COUNT) || (state_q == ALARM));

`ifdef MATCH_CNT_SAT_EN
   assign count_inc = at_max ? count_q : count_q + 1'b1;
`else
   assign count_inc = count_q + 1'b1;
`endif

   // Compared against the post-increment value so a new thresh only matters at the next event.
   assign thresh_reached = (thresh != '0) && (count_inc >= thresh);

   always_comb begin
      state_d       = state_q;
      z_d           = z_in;
      count_d       = count_q;
      match_pulse_d = 1'b0;
      alarm_d       = alarm_q;
      ovf_d         = ovf_q;
      rd_valid_d    = rd_req;
      rd_data_d     = rd_req ? count_q : rd_data_q;

      if (clr) begin
         count_d = '0;
         alarm_d = 1'b0;
         ovf_d   = 1'b0;
         state_d = en ? COUNT : IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               // A still-set alarm survives an en=0 pause, so resume in ALARM.
               if (en) state_d = alarm_q ? ALARM : COUNT;
            end
            COUNT, ALARM: begin
               if (!en) begin
                  state_d = IDLE;
               end else if (event_hit) begin
                  count_d       = count_inc;
                  match_pulse_d = 1'b1;
                  if (at_max) ovf_d = 1'b1;
                  if (thresh_reached) begin
                     alarm_d = 1'b1;
                     state_d = ALARM;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         z_q           <= 1'b0;
         count_q       <= '0;
         match_pulse_q <= 1'b0;
         alarm_q       <= 1'b0;
         ovf_q         <= 1'b0;
         rd_valid_q    <= 1'b0;
         rd_data_q     <= '0;
      end else begin
         state_q       <= state_d;
         z_q           <= z_d;
         count_q       <= count_d;
         match_pulse_q <= match_pulse_d;
         alarm_q       <= alarm_d;
         ovf_q         <= ovf_d;
         rd_valid_q    <= rd_valid_d;
         rd_data_q     <= rd_data_d;
      end
   end

   assign count       = count_q;
   assign match_pulse = match_pulse_q;
   assign alarm       = alarm_q;
   assign ovf         = ovf_q;
   assign rd_valid    = rd_valid_q;
   assign rd_data     = rd_data_q;

   logic unused_counting;
   assign unused_counting = counting;

endmodule

// File: tb/tb_match_event_counter.sv
// Directed bench for match_event_counter: a reference model pushes expected outputs to a queue
// as each cycle is driven; entries are popped and compared one cycle later.
module tb_match_event_counter;

   localparam int CNT_W = 8;

   typedef struct packed {
      logic [CNT_W-1:0] count;
      logic             mp;
      logic             alarm;
      logic             ovf;
      logic             rv;
      logic [CNT_W-1:0] rd;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset, z_in, en, clr, rd_req;
   logic [CNT_W-1:0] thresh;
   logic [CNT_W-1:0] count, rd_data;
   logic             match_pulse, alarm, ovf, rd_valid;

   int checks = 0;
   int errors = 0;

   exp_t exp_q[$];

   // reference model state
   int   m_state;   // 0 idle, 1 count, 2 alarm
   bit   m_z, m_mp, m_alarm, m_ovf, m_rv;
   int   m_count, m_rd;
   logic cur_en;
   logic [CNT_W-1:0] cur_th;
   int   mp_seen;

   match_event_counter #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .z_in(z_in), .en(en), .clr(clr), .thresh(thresh),
      .rd_req(rd_req), .count(count), .match_pulse(match_pulse), .alarm(alarm),
      .ovf(ovf), .rd_valid(rd_valid), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", name, obs, expv);
      end
   endtask

   task automatic model(input bit r, input bit z, input bit e, input bit c, input bit rq, input int th);
      bit ev;
      int nc;
      exp_t x;
      if (r) begin
         m_state = 0; m_z = 0; m_count = 0; m_mp = 0; m_alarm = 0; m_ovf = 0; m_rv = 0; m_rd = 0;
      end else begin
         ev   = z && !m_z;
         m_z  = z;
         m_mp = 0;
         m_rv = rq;
         if (rq) m_rd = m_count;
         if (c) begin
            m_count = 0; m_alarm = 0; m_ovf = 0;
            m_state = e ? 1 : 0;
         end else if (m_state == 0) begin
            if (e) m_state = m_alarm ? 2 : 1;
         end else if (!e) begin
            m_state = 0;
         end else if (ev) begin
            m_mp = 1;
            if (m_count == (1 << CNT_W) - 1) begin
               m_ovf = 1;
`ifdef MATCH_CNT_SAT_EN
               nc = m_count;
`else
               nc = 0;
`endif
            end else begin
               nc = m_count + 1;
            end
            m_count = nc;
            if (th != 0 && nc >= th) begin
               m_alarm = 1; m_state = 2;
            end
         end
      end
      x.count = m_count[CNT_W-1:0]; x.mp = m_mp; x.alarm = m_alarm; x.ovf = m_ovf;
      x.rv = m_rv; x.rd = m_rd[CNT_W-1:0];
      exp_q.push_back(x);
   endtask

   task automatic step(input bit r, input bit z, input bit c, input bit rq);
      exp_t x;
      reset = r; z_in = z; en = cur_en; clr = c; rd_req = rq; thresh = cur_th;
      model(r, z, cur_en, c, rq, int'(cur_th));
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      if (match_pulse === 1'b1) mp_seen++;
      checks++;
      assert ({count, match_pulse, alarm, ovf, rd_valid, rd_data} === x) else begin
         errors++;
         $error("FAIL sb_cycle: observed cnt=%0d mp=%b al=%b ovf=%b rv=%b rd=%0d expected cnt=%0d mp=%b al=%b ovf=%b rv=%b rd=%0d",
                count, match_pulse, alarm, ovf, rd_valid, rd_data,
                x.count, x.mp, x.alarm, x.ovf, x.rv, x.rd);
      end
      $display("t=%0t rst=%b z=%b en=%b clr=%b rd=%b th=%0d -> cnt=%0d mp=%b al=%b ovf=%b rv=%b rd=%0d",
               $time, r, z, cur_en, c, rq, cur_th, count, match_pulse, alarm, ovf, rd_valid, rd_data);
   endtask

   task automatic pulse();
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
   endtask

   initial begin
      cur_en = 0; cur_th = '0; mp_seen = 0;
      reset = 1; z_in = 0; en = 0; clr = 0; rd_req = 0; thresh = '0;

      // reset state
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("reset_count", int'(count), 0);
      chk("reset_flags", int'({match_pulse, alarm, ovf, rd_valid}), 0);

      // three single-cycle events with thresh=3
      cur_en = 1; cur_th = 8'd3;
      step(0, 0, 0, 0);
      mp_seen = 0;
      step(0, 1, 0, 0);
      chk("ev1_count", int'(count), 1);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      chk("ev2_count", int'(count), 2);
      chk("ev2_alarm", int'(alarm), 0);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      chk("ev3_count", int'(count), 3);
      chk("ev3_alarm", int'(alarm), 1);
      step(0, 0, 0, 0);
      chk("three_pulses", mp_seen, 3);

      // clear returns to COUNT, alarm off
      step(0, 0, 1, 0);
      chk("clr_alarm", int'(alarm), 0);
      chk("clr_count", int'(count), 0);

      // level held high ten cycles counts once
      cur_th = '0;
      mp_seen = 0;
      for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      chk("held_count", int'(count), 1);
      chk("held_pulses", mp_seen, 1);

      // bring count to 5, then clr + event + rd_req together
      for (int i = 0; i < 4; i++) pulse();
      chk("pre_clr_count", int'(count), 5);
      step(0, 1, 1, 1);
      chk("coinc_count", int'(count), 0);
      chk("coinc_mp", int'(match_pulse), 0);
      chk("coinc_rd_data", int'(rd_data), 5);
      chk("coinc_rd_valid", int'(rd_valid), 1);
      step(0, 0, 0, 0);
      chk("rd_valid_drop", int'(rd_valid), 0);
      chk("rd_data_hold", int'(rd_data), 5);

      // disabled: events ignored
      cur_en = 0;
      step(0, 0, 0, 0);
      mp_seen = 0;
      for (int i = 0; i < 4; i++) pulse();
      chk("dis_count", int'(count), 0);
      chk("dis_pulses", mp_seen, 0);
      cur_en = 1;
      step(0, 0, 0, 0);
      pulse();
      chk("reen_count", int'(count), 1);

      // back-to-back snapshots
      step(0, 0, 0, 1);
      chk("b2b_rv1", int'(rd_valid), 1);
      step(0, 0, 0, 1);
      chk("b2b_rv2", int'(rd_valid), 1);
      chk("b2b_rd", int'(rd_data), 1);
      step(0, 0, 0, 0);

      // lowering thresh below count is not retroactive
      cur_th = 8'd1;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("th_no_retro", int'(alarm), 0);
      pulse();
      chk("th_next_event", int'(alarm), 1);

      // reset in ALARM at count 7
      for (int i = 0; i < 5; i++) pulse();
      chk("pre_rst_count", int'(count), 7);
      step(1, 0, 0, 1);
      chk("alarm_rst_all", int'({count, match_pulse, alarm, ovf, rd_valid, rd_data}), 0);

      // run up to max and overflow
      cur_en = 1; cur_th = '0;
      step(0, 0, 0, 0);
      for (int i = 0; i < 255; i++) pulse();
      chk("max_count", int'(count), 255);
      chk("max_ovf", int'(ovf), 0);
      step(0, 1, 0, 0);
`ifdef MATCH_CNT_SAT_EN
      chk("ovf_count", int'(count), 255);
`else
      chk("ovf_count", int'(count), 0);
`endif
      chk("ovf_flag", int'(ovf), 1);
      chk("ovf_mp", int'(match_pulse), 1);
      step(0, 0, 0, 0);
      chk("ovf_sticky", int'(ovf), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/match_event_counter.md
MATCH_EVENT_COUNTER -- requirements
Module: match_event_counter

Interface
REQ-001 Parameter: CNT_W, default 8, width of event count, threshold and readout data.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 z_in  input  1  detection flag from the upstream 1001 sequence detector, level, clk-synchronous.
REQ-005 en  input  1  counting enable; low = block idles and ignores z_in edges.
REQ-006 clr  input  1  synchronous clear of count, alarm and ovf.
REQ-007 thresh  input  CNT_W  alarm threshold; 0 = alarm disabled.
REQ-008 rd_req  input  1  single-cycle snapshot request.
REQ-009 count  output  CNT_W  live event count, registered.
REQ-010 match_pulse  output  1  one-cycle registered pulse per counted event.
REQ-011 alarm  output  1  sticky threshold-reached flag.
REQ-012 ovf  output  1  sticky count-limit flag.
REQ-013 rd_valid  output  1  one-cycle strobe qualifying rd_data.
REQ-014 rd_data  output  CNT_W  snapshot of count.

Function
REQ-015 The block SHALL register z_in into z_q every cycle; an event is z_in=1 with z_q=0 at a clock edge (rising edge of z_in).
REQ-016 A z_in level held high for N cycles SHALL count as exactly one event.
REQ-017 FSM states: IDLE, COUNT, ALARM; encoding is free.
REQ-018 IDLE -> COUNT when en=1; COUNT/ALARM -> IDLE when en=0; IDLE ignores events and holds count.
REQ-019 In COUNT or ALARM, an event SHALL increment count at that same edge and assert match_pulse for the following cycle only.
REQ-020 COUNT -> ALARM at the edge where the incremented count equals or exceeds thresh and thresh != 0; alarm=1 from the next cycle.
REQ-021 ALARM SHALL persist, with alarm=1, until clr or reset; counting continues in ALARM.
REQ-022 clr=1 SHALL set count=0, alarm=0, ovf=0, and move ALARM -> COUNT (en=1) or IDLE (en=0); clr wins over a coincident event (no increment, no match_pulse).
REQ-023 rd_req=1 at edge k SHALL load rd_data with the count value present before edge k and assert rd_valid for the cycle after edge k only.
REQ-024 rd_req coincident with clr or an event SHALL capture the pre-update count.
REQ-025 rd_data SHALL hold its last value between requests; back-to-back rd_req SHALL give back-to-back rd_valid.
REQ-026 Overflow handling at count = 2^CNT_W-1 SHALL follow REQ-031/REQ-032; ovf is set at the edge where an event arrives at max count.
REQ-027 Changing thresh while in COUNT SHALL take effect at the next event; it SHALL NOT retroactively assert alarm.

Reset
REQ-028 reset=1 at a clock edge SHALL force state=IDLE, count=0, z_q=0, match_pulse=0, alarm=0, ovf=0, rd_valid=0, rd_data=0.
REQ-029 reset SHALL take priority over clr, en, rd_req and events, including mid-count and in ALARM.
REQ-030 After release, the first event SHALL require en=1 and a fresh rising edge of z_in sampled after reset (z_in high during reset release counts as an edge).

Configuration
REQ-031 With macro MATCH_CNT_SAT_EN defined, count SHALL saturate at 2^CNT_W-1; further events set ovf, still pulse match_pulse, and leave count unchanged.
REQ-032 Without MATCH_CNT_SAT_EN, count SHALL wrap from 2^CNT_W-1 to 0, set ovf, and pulse match_pulse.

Verification
REQ-033 reset, en=1, thresh=3, z_in pulses 1 cycle x3 -> count 1,2,3; three match_pulse; alarm=1 the cycle after third event.
REQ-034 z_in held high 10 cycles, en=1 -> count +1 only, single match_pulse.
REQ-035 count=5, clr and z_in rising edge same cycle, rd_req same cycle -> count=0, no match_pulse, rd_data=5, rd_valid one cycle.
REQ-036 CNT_W=8, count=255, event -> with MATCH_CNT_SAT_EN count=255, ovf=1; without it count=0, ovf=1.
REQ-037 en=0, 4 z_in events -> count unchanged, no match_pulse; en=1 then one event -> count +1.
REQ-038 ALARM state, count=7, reset asserted 1 cycle -> all outputs 0, state IDLE next cycle.
